// File: rtl/wisc_alu_pkg.sv
// ------------------------------------------------------------------------
// wisc_alu_pkg : shared opcode, flag and state types for the WISC pipelined ALU
// Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

package wisc_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'h0,
    OP_SUB    = 4'h1,
    OP_XOR    = 4'h2,
    OP_RED    = 4'h3,
    OP_SLL    = 4'h4,
    OP_SRA    = 4'h5,
    OP_ROR    = 4'h6,
    OP_PADDSB = 4'h7,
    OP_LW     = 4'h8,
    OP_SW     = 4'h9,
    OP_LLB    = 4'hA,
    OP_LHB    = 4'hB,
    OP_RSV_C  = 4'hC,
    OP_RSV_D  = 4'hD,
    OP_RSV_E  = 4'hE,
    OP_RSV_F  = 4'hF
  } alu_op_t;

  typedef struct packed {
    logic z;
    logic v;
    logic n;
  } flags_t;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RED_ACC = 1'b1
  } alu_state_t;

  // Saturation bounds for widths up to 64 bits; callers take the low w bits.
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/wisc_alu_pipe_if.sv
// ------------------------------------------------------------------------
// wisc_alu_pipe_if : operand/result handshake bundle of the WISC pipelined ALU
// Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

interface wisc_alu_pipe_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        opcode;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result;
  logic [2:0]        flags;

  modport master (
    output in_valid, opcode, a, b, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, opcode, a, b, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

`default_nettype wire

// File: rtl/wisc_sat_add.sv
// ------------------------------------------------------------------------
// wisc_sat_add : W-bit signed add/subtract with saturation and overflow flags
// Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module wisc_sat_add
  import wisc_alu_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sub,
  output logic [W-1:0] o_sum,
  output logic         o_pos_ovf,
  output logic         o_neg_ovf
);
  localparam logic [63:0] c_max = sat_max(W);
  localparam logic [63:0] c_min = sat_min(W);

  logic [W:0] w_a_ext;
  logic [W:0] w_b_ext;
  logic [W:0] w_raw;

  // One guard bit: the top two bits disagree exactly when the true result left the W-bit range.
  always_comb begin
    w_a_ext   = {i_a[W-1], i_a};
    w_b_ext   = {i_b[W-1], i_b};
    w_raw     = i_sub ? (w_a_ext - w_b_ext) : (w_a_ext + w_b_ext);
    o_pos_ovf = (w_raw[W:W-1] == 2'b01);
    o_neg_ovf = (w_raw[W:W-1] == 2'b10);
    if (o_pos_ovf) begin
      o_sum = c_max[W-1:0];
    end else if (o_neg_ovf) begin
      o_sum = c_min[W-1:0];
    end else begin
      o_sum = w_raw[W-1:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/wisc_alu_pipe.sv
// ------------------------------------------------------------------------
// wisc_alu_pipe : pipelined WISC execute ALU with Z/V/N flags; WISC_ALU_RED_ITER_EN makes RED iterative
// Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module wisc_alu_pipe
  import wisc_alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int LANE_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  wisc_alu_pipe_if.slave  bus
);
  localparam int LANES   = DATA_W / LANE_W;
  localparam int SHAMT_W = $clog2(DATA_W);

  alu_op_t           w_op;
  logic              w_idle;
  logic              w_accept;
  logic              w_wr;
  logic [DATA_W-1:0] w_wr_val;
  logic [DATA_W-1:0] w_alu;
  logic [DATA_W-1:0] w_red_val;
  logic [DATA_W-1:0] w_add_sum;
  logic              w_add_pos;
  logic              w_add_neg;
  logic [DATA_W-1:0] w_paddsb;
  logic [LANES-1:0]  w_unused_lane_pos;
  logic [LANES-1:0]  w_unused_lane_neg;
  logic [SHAMT_W-1:0] w_shamt;

  flags_t            flags_q, flags_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] result_q, result_d;

  assign w_op     = alu_op_t'(bus.opcode);
  assign w_shamt  = bus.b[SHAMT_W-1:0];
  assign bus.in_ready = rst_n && w_idle && (!out_valid_q || bus.out_ready);
  assign w_accept = bus.in_valid && bus.in_ready && !flush;

  wisc_sat_add #(.W(DATA_W)) u_add (
    .i_a       (bus.a),
    .i_b       (bus.b),
    .i_sub     (w_op == OP_SUB),
    .o_sum     (w_add_sum),
    .o_pos_ovf (w_add_pos),
    .o_neg_ovf (w_add_neg)
  );

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    wisc_sat_add #(.W(LANE_W)) u_lane_add (
      .i_a       (bus.a[gi*LANE_W +: LANE_W]),
      .i_b       (bus.b[gi*LANE_W +: LANE_W]),
      .i_sub     (1'b0),
      .o_sum     (w_paddsb[gi*LANE_W +: LANE_W]),
      .o_pos_ovf (w_unused_lane_pos[gi]),
      .o_neg_ovf (w_unused_lane_neg[gi])
    );
  end

  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_ADD, OP_SUB: w_alu = w_add_sum;
      OP_XOR:         w_alu = bus.a ^ bus.b;
      OP_RED:         w_alu = w_red_val;
      OP_SLL:         w_alu = bus.a << w_shamt;
      OP_SRA:         w_alu = $signed(bus.a) >>> w_shamt;
      OP_ROR:         w_alu = (bus.a >> w_shamt) | (bus.a << (DATA_W - int'(w_shamt)));
      OP_PADDSB:      w_alu = w_paddsb;
      OP_LW, OP_SW:   w_alu = bus.a + bus.b;
      OP_LLB:         w_alu = {bus.a[DATA_W-1:8], bus.b[7:0]};
      OP_LHB: begin
        w_alu        = bus.a;
        w_alu[15:8]  = bus.b[7:0];
      end
      default:        w_alu = '0;
    endcase
  end

`ifdef WISC_ALU_RED_ITER_EN
  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [0:0] c_st_idle    = IDLE;
  localparam logic [0:0] c_st_red_acc = RED_ACC;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(LANES - 1);

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [LANE_W-1:0] w_lane_a;
  logic [LANE_W-1:0] w_lane_b;
  logic [DATA_W-1:0] w_acc_next;
  logic              w_red_done;

  assign w_idle    = (state_q == c_st_idle);
  assign w_red_val = '0;

  always_comb begin
    w_lane_a   = opa_q[cnt_q*LANE_W +: LANE_W];
    w_lane_b   = opb_q[cnt_q*LANE_W +: LANE_W];
    w_acc_next = acc_q + DATA_W'($signed(w_lane_a)) + DATA_W'($signed(w_lane_b));
    w_red_done = (state_q == c_st_red_acc) && (cnt_q == c_cnt_last);
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    if (state_q == c_st_red_acc) begin
      acc_d = w_acc_next;
      cnt_d = cnt_q + 1'b1;
      if (w_red_done) begin
        state_d = c_st_idle;
        cnt_d   = '0;
      end
    end else if (w_accept && (w_op == OP_RED)) begin
      state_d = c_st_red_acc;
      cnt_d   = '0;
      acc_d   = '0;
      opa_d   = bus.a;
      opb_d   = bus.b;
    end
    if (flush) begin
      state_d = c_st_idle;
      cnt_d   = '0;
      acc_d   = '0;
    end
    w_wr     = (w_accept && (w_op != OP_RED)) || (w_red_done && !flush);
    w_wr_val = w_red_done ? w_acc_next : w_alu;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_st_idle;
      cnt_q   <= '0;
      acc_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
    end
  end
`else
  assign w_idle = 1'b1;

  always_comb begin
    w_red_val = '0;
    for (int i = 0; i < LANES; i++) begin
      w_red_val = w_red_val + DATA_W'($signed(bus.a[i*LANE_W +: LANE_W]))
                            + DATA_W'($signed(bus.b[i*LANE_W +: LANE_W]));
    end
  end

  assign w_wr     = w_accept;
  assign w_wr_val = w_alu;
`endif

  // Flags follow the accepted op; RED, PADDSB and memory/byte ops leave them alone.
  always_comb begin
    flags_d = flags_q;
    if (w_accept) begin
      case (w_op)
        OP_ADD, OP_SUB: begin
          flags_d.z = (w_add_sum == '0);
          flags_d.v = w_add_pos | w_add_neg;
          flags_d.n = w_add_sum[DATA_W-1];
        end
        OP_XOR, OP_SLL, OP_SRA, OP_ROR: flags_d.z = (w_alu == '0);
        default: ;
      endcase
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    if (bus.out_ready) out_valid_d = 1'b0;
    if (w_wr)          out_valid_d = 1'b1;
    if (flush)         out_valid_d = 1'b0;
    result_d = w_wr ? w_wr_val : result_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;

endmodule

`default_nettype wire

// File: tb/tb_wisc_alu_pipe.sv
// ------------------------------------------------------------------------
// tb_wisc_alu_pipe : directed self-checking bench for wisc_alu_pipe (both RED builds)
// Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module tb_wisc_alu_pipe;
  import wisc_alu_pkg::*;

`ifdef WISC_ALU_RED_ITER_EN
  localparam int c_red_lat = 4;
`else
  localparam int c_red_lat = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   lat;
  int   low;

  wisc_alu_pipe_if #(.DATA_W(16)) bus ();

  wisc_alu_pipe #(.DATA_W(16), .LANE_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input alu_op_t op, input logic [15:0] a, input logic [15:0] b);
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.a        = a;
    bus.b        = b;
  endtask

  task automatic issue(input string tag, input alu_op_t op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] er, input logic [2:0] ef);
    drive(op, a, b);
    chk({tag, " in_ready"}, bus.in_ready, 1);
    tick();
    chk({tag, " out_valid"}, bus.out_valid, 1);
    chk({tag, " result"}, bus.result, er);
    chk({tag, " flags"}, bus.flags, ef);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.opcode    = '0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("rst out_valid", bus.out_valid, 0);
    chk("rst result", bus.result, 0);
    chk("rst flags", bus.flags, 0);
    chk("rst in_ready", bus.in_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("post-rst in_ready", bus.in_ready, 1);

    // back-to-back stream, out_ready held high
    issue("add_sat",  OP_ADD,    16'h7FFF, 16'h0001, 16'h7FFF, 3'b010);
    issue("sub_sat",  OP_SUB,    16'h8000, 16'h0001, 16'h8000, 3'b011);
    issue("xor_zero", OP_XOR,    16'h1234, 16'h1234, 16'h0000, 3'b111);
    issue("paddsb",   OP_PADDSB, 16'h7322, 16'h1A11, 16'h7D33, 3'b111);
    issue("llb",      OP_LLB,    16'hABCD, 16'h0012, 16'hAB12, 3'b111);
    issue("sra",      OP_SRA,    16'h8000, 16'h0003, 16'hF000, 3'b011);
    issue("ror",      OP_ROR,    16'h1234, 16'h0004, 16'h4123, 3'b011);
    issue("sll",      OP_SLL,    16'h0001, 16'h000F, 16'h8000, 3'b011);
    issue("lhb",      OP_LHB,    16'hABCD, 16'h0012, 16'h12CD, 3'b011);
    issue("lw_wrap",  OP_LW,     16'h7FFF, 16'h0001, 16'h8000, 3'b011);
    issue("rsv_c",    OP_RSV_C,  16'hFFFF, 16'hFFFF, 16'h0000, 3'b011);
    bus.in_valid = 1'b0;
    tick();
    chk("drained out_valid", bus.out_valid, 0);

    // RED latency and in_ready blackout
    drive(OP_RED, 16'h7777, 16'h7777);
    chk("red in_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    low = 0;
    while (!bus.out_valid && lat < 20) begin
      if (!bus.in_ready) low++;
      tick();
      lat++;
    end
    chk("red latency", lat, c_red_lat);
    chk("red in_ready low cycles", low, c_red_lat);
    chk("red result", bus.result, 16'h0038);
    chk("red flags", bus.flags, 3'b011);
    chk("red done in_ready", bus.in_ready, 1);

    // backpressure: hold XOR result, then drain while an ADD waits
    drive(OP_XOR, 16'hF0F0, 16'h0F0F);
    tick();
    chk("bp xor result", bus.result, 16'hFFFF);
    chk("bp xor flags", bus.flags, 3'b011);
    bus.out_ready = 1'b0;
    drive(OP_ADD, 16'hFFFF, 16'hFFFF);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp hold out_valid", bus.out_valid, 1);
      chk("bp hold result", bus.result, 16'hFFFF);
      chk("bp hold flags", bus.flags, 3'b011);
      chk("bp hold in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("drain in_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    chk("drain add out_valid", bus.out_valid, 1);
    chk("drain add result", bus.result, 16'hFFFE);
    chk("drain add flags", bus.flags, 3'b001);

    // op offered during flush is discarded
    drive(OP_XOR, 16'h0001, 16'h0001);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush op out_valid", bus.out_valid, 0);
    chk("flush op flags", bus.flags, 3'b001);

    // flush in the 2nd cycle of RED
    drive(OP_RED, 16'h1111, 16'h1111);
    tick();
    bus.in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush red out_valid", bus.out_valid, 0);
    chk("flush red in_ready", bus.in_ready, 1);
    chk("flush red flags", bus.flags, 3'b001);
    tick();
    tick();
    chk("flush red stays idle", bus.out_valid, 0);

    // asynchronous reset mid-RED
    drive(OP_RED, 16'h7777, 16'h7777);
    tick();
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst out_valid", bus.out_valid, 0);
    chk("async rst result", bus.result, 0);
    chk("async rst flags", bus.flags, 0);
    chk("async rst in_ready", bus.in_ready, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("re-rst in_ready", bus.in_ready, 1);
    issue("post_rst_add", OP_ADD, 16'h0002, 16'h0003, 16'h0005, 3'b000);
    bus.in_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
